// File: rtl/demap_align_pkg.sv
// Shared types and helpers for the link demapper/aligner: FSM states, default
// alignment word, counter width and the per-byte bit demap.
package demap_align_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [31:0] ALIGN_PAT_DEF = 32'hA1B2C3D4;
  localparam int          CNT_W         = 4;

  // out[0..7] = in[7,5,3,1,6,4,2,0]; undoes the transmit-side bit scatter.
  function automatic logic [7:0] demap8(input logic [7:0] b);
    return {b[0], b[2], b[4], b[6], b[1], b[3], b[5], b[7]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/demap_align_byte.sv
// 8-bit combinational bit demap for one byte lane.
module demap_byte
  import demap_align_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = demap8(i_byte);

endmodule

// File: rtl/demap_align.sv
// Byte demap plus word alignment: hunts for ALIGN_PAT at one of four byte
// offsets in a two-word window, verifies it, and emits aligned words once locked.
module demap_align
  import demap_align_pkg::*;
#(
  parameter logic [31:0] ALIGN_PAT = ALIGN_PAT_DEF,
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned LOSS_CNT  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bypass,
  input  logic [31:0] din,
  input  logic        din_valid,
  input  logic        realign,
  output logic [31:0] dout,
  output logic        dout_valid,
  output logic        locked,
  output logic [1:0]  offset,
  output logic        align_err
);

  localparam logic [CNT_W-1:0] LOCK_C = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] LOSS_C = CNT_W'(LOSS_CNT);

  logic [31:0]      w_dm, w_word;
  logic [63:0]      w_win;
  logic [3:0][31:0] w_cand;
  logic [3:0]       w_hit;
  logic             w_any;
  logic [1:0]       w_k;

  logic [31:0]      r_d_prev, r_d_cur, r_dout;
  logic             r_eval, r_dout_valid, r_locked, r_align_err;
  logic [1:0]       r_offset, r_cand_off;
  logic [CNT_W-1:0] r_cnt, r_miss_cnt;
  state_t           r_state;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    demap_byte u_demap (
      .i_byte (din[8*i +: 8]),
      .o_byte (w_dm[8*i +: 8])
    );
  end

  assign w_word = bypass ? din : w_dm;
  assign w_win  = {r_d_cur, r_d_prev};

  for (genvar k = 0; k < 4; k++) begin : g_cand
    assign w_cand[k] = w_win[8*k +: 32];
    assign w_hit[k]  = (w_cand[k] == ALIGN_PAT);
  end

  // Priority pick: lowest matching offset wins.
  always_comb begin
    w_any = 1'b0;
    w_k   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (w_hit[k]) begin
        w_any = 1'b1;
        w_k   = 2'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_prev     <= '0;
      r_d_cur      <= '0;
      r_eval       <= 1'b0;
      r_state      <= HUNT;
      r_cnt        <= '0;
      r_miss_cnt   <= '0;
      r_cand_off   <= 2'd0;
      r_offset     <= 2'd0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_align_err  <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      r_align_err  <= 1'b0;
      r_eval       <= din_valid;
      if (din_valid) begin
        r_d_prev <= r_d_cur;
        r_d_cur  <= w_word;
      end
      if (realign) begin
        r_state    <= HUNT;
        r_cnt      <= '0;
        r_miss_cnt <= '0;
        r_locked   <= 1'b0;
      end else if (r_eval) begin
        case (r_state)
          HUNT: if (w_any) begin
            r_cand_off <= w_k;
            r_cnt      <= CNT_W'(1);
            if (LOCK_C == CNT_W'(1)) begin
              r_state      <= LOCKED;
              r_locked     <= 1'b1;
              r_offset     <= w_k;
              r_miss_cnt   <= '0;
              r_dout       <= w_cand[w_k];
              r_dout_valid <= 1'b1;
            end else begin
              r_state <= VERIFY;
            end
          end
          VERIFY: if (w_hit[r_cand_off]) begin
            r_cnt <= sat_inc(r_cnt);
            if (sat_inc(r_cnt) >= LOCK_C) begin
              // The word that completes the lock is emitted too.
              r_state      <= LOCKED;
              r_locked     <= 1'b1;
              r_offset     <= r_cand_off;
              r_miss_cnt   <= '0;
              r_dout       <= w_cand[r_cand_off];
              r_dout_valid <= 1'b1;
            end
          end else begin
            r_state <= HUNT;
            r_cnt   <= '0;
          end
          LOCKED: begin
            r_dout       <= w_cand[r_offset];
            r_dout_valid <= 1'b1;
            if (w_any && (w_k == r_offset)) begin
              r_miss_cnt <= '0;
            end else if (w_any) begin
              if (sat_inc(r_miss_cnt) >= LOSS_C) begin
                r_state     <= HUNT;
                r_locked    <= 1'b0;
                r_align_err <= 1'b1;
                r_miss_cnt  <= '0;
                r_cnt       <= '0;
              end else begin
                r_miss_cnt <= sat_inc(r_miss_cnt);
              end
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign locked     = r_locked;
  assign offset     = r_offset;
  assign align_err  = r_align_err;

endmodule

// File: tb/tb_demap_align.sv
// Directed bench for demap_align: demap, lock at offsets 0/2, loss of lock,
// realign, VERIFY break and asynchronous reset, with hand-computed expectations.
module tb_demap_align;
  import demap_align_pkg::*;

  logic        clk = 1'b0;
  logic        rst, bypass, din_valid, realign;
  logic [31:0] din, dout;
  logic        dout_valid, locked, align_err;
  logic [1:0]  offset;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [31:0] PAT = 32'hA1B2C3D4;

  demap_align dut (
    .clk        (clk),
    .rst        (rst),
    .bypass     (bypass),
    .din        (din),
    .din_valid  (din_valid),
    .realign    (realign),
    .dout       (dout),
    .dout_valid (dout_valid),
    .locked     (locked),
    .offset     (offset),
    .align_err  (align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Transmit-side scatter, written independently: in[m[n]] carries out[n].
  function automatic logic [7:0] tx8(input logic [7:0] b);
    logic [7:0] t;
    int m[8] = '{7, 5, 3, 1, 6, 4, 2, 0};
    t = '0;
    for (int n = 0; n < 8; n++) t[m[n]] = b[n];
    return t;
  endfunction

  function automatic logic [31:0] tx32(input logic [31:0] w);
    logic [31:0] t;
    for (int i = 0; i < 4; i++) t[8*i +: 8] = tx8(w[8*i +: 8]);
    return t;
  endfunction

  // One qualified word, then its evaluation cycle; outputs settle on return.
  task automatic word(input logic [31:0] w, input logic ra = 1'b0);
    din       = w;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    realign   = ra;
    @(posedge clk); #1;
    realign   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bypass = 1'b0; din = '0; din_valid = 1'b0; realign = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout",       dout,              32'h0);
    chk("rst_dout_valid", 32'(dout_valid),   32'h0);
    chk("rst_locked",     32'(locked),       32'h0);
    chk("rst_offset",     32'(offset),       32'h0);
    chk("rst_align_err",  32'(align_err),    32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Demap of single-bit bytes
    chk("pkg_roundtrip", 32'(demap8(tx8(8'hD4))), 32'hD4);
    word(32'h80808080);
    chk("demap_80", dut.r_d_cur, 32'h01010101);
    word(32'h40404040);
    chk("demap_40",      dut.r_d_cur,  32'h10101010);
    chk("demap_40_prev", dut.r_d_prev, 32'h01010101);

    // Lock at offset 0: first word only fills the window, next four match
    bypass = 1'b1;
    repeat (4) word(PAT);
    chk("lock0_not_yet", 32'(locked), 32'h0);
    chk("lock0_verify",  32'(dut.r_state), 32'(VERIFY));
    word(PAT);
    chk("lock0_locked", 32'(locked),     32'h1);
    chk("lock0_dv",     32'(dout_valid), 32'h1);
    chk("lock0_dout",   dout,            PAT);
    chk("lock0_offset", 32'(offset),     32'h0);
    @(posedge clk); #1;
    chk("hold_dv",   32'(dout_valid), 32'h0);
    chk("hold_dout", dout,            PAT);

    // Loss of lock: B2C3D4A1 repeated matches at k=1
    word(32'hB2C3D4A1);
    chk("loss_first_at_off", dout, PAT);
    word(32'hB2C3D4A1);
    word(32'hB2C3D4A1);
    chk("loss_miss2_dout",   dout,             32'hB2C3D4A1);
    chk("loss_miss2_locked", 32'(locked),      32'h1);
    chk("loss_miss2_err",    32'(align_err),   32'h0);
    word(32'hB2C3D4A1);
    chk("loss_err_pulse", 32'(align_err), 32'h1);
    chk("loss_unlocked",  32'(locked),    32'h0);
    @(posedge clk); #1;
    chk("loss_err_once", 32'(align_err), 32'h0);

    // Lock at offset 2: C3D4A1B2 repeated gives k=2 each word
    repeat (4) word(32'hC3D4A1B2);
    chk("off2_hold_offset", 32'(offset), 32'h0);
    chk("off2_not_locked",  32'(locked), 32'h0);
    word(32'hC3D4A1B2);
    chk("off2_locked", 32'(locked),     32'h1);
    chk("off2_offset", 32'(offset),     32'h2);
    chk("off2_dout",   dout,            PAT);
    chk("off2_dv",     32'(dout_valid), 32'h1);

    // Realign coincident with a match
    word(32'hC3D4A1B2, 1'b1);
    chk("realign_locked", 32'(locked),        32'h0);
    chk("realign_err",    32'(align_err),     32'h0);
    chk("realign_dv",     32'(dout_valid),    32'h0);
    chk("realign_state",  32'(dut.r_state),   32'(HUNT));
    chk("realign_offset", 32'(offset),        32'h2);

    // VERIFY break: three k=0 matches, then a miss
    word(32'h12345678);
    repeat (3) word(PAT);
    word(32'h12345678);
    chk("vbrk_state3", 32'(dut.r_state), 32'(VERIFY));
    chk("vbrk_cnt3",   32'(dut.r_cnt),   32'h3);
    word(32'h9ABCDEF0);
    chk("vbrk_state",  32'(dut.r_state), 32'(HUNT));
    chk("vbrk_cnt",    32'(dut.r_cnt),   32'h0);
    chk("vbrk_locked", 32'(locked),      32'h0);
    chk("vbrk_err",    32'(align_err),   32'h0);

    // Asynchronous reset mid-VERIFY
    word(PAT);
    word(PAT);
    chk("arst_pre_state", 32'(dut.r_state), 32'(VERIFY));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_dout",   dout,              32'h0);
    chk("arst_dv",     32'(dout_valid),   32'h0);
    chk("arst_locked", 32'(locked),       32'h0);
    chk("arst_offset", 32'(offset),       32'h0);
    chk("arst_err",    32'(align_err),    32'h0);
    chk("arst_dcur",   dut.r_d_cur,       32'h0);
    chk("arst_state",  32'(dut.r_state),  32'(HUNT));
    @(posedge clk); #1;
    rst = 1'b0;

    // Mapped stream through the demap path, with latency check on the lock word
    bypass = 1'b0;
    repeat (4) word(tx32(PAT));
    chk("map_dcur", dut.r_d_cur, PAT);
    din = tx32(PAT); din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    chk("lat_dv_early", 32'(dout_valid), 32'h0);
    @(posedge clk); #1;
    chk("lat_dv",      32'(dout_valid), 32'h1);
    chk("map_dout",    dout,            PAT);
    chk("map_locked",  32'(locked),     32'h1);
    chk("map_offset",  32'(offset),     32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
